// File: rtl/ula_serial.sv
// Bit-serial ALU: AND/OR/ADD/SUB/SLT processed SLICE bits per clock, LSB slice first.
// Results and flags are registered and only change on completion.
module ula_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ulaOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_In,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             c_Out,
    output logic             ovf,
    output logic             zero,
    output logic             err
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             carry_q, carry_d, sovf_q, sovf_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

    logic [SLICE-1:0] as, bs, rs;
    logic [SLICE:0]   sum;
    logic             sub, arith, legal, last, cmsb, slice_ovf, slt_bit;

    // Datapath for the current slice; operands are shifted right so slice 0 is always in view.
    always_comb begin
        sub       = (op_q == OP_SUB) || (op_q == OP_SLT);
        arith     = (op_q == OP_ADD) || sub;
        as        = a_q[SLICE-1:0];
        bs        = sub ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
        sum       = {1'b0, as} + {1'b0, bs} + {{SLICE{1'b0}}, carry_q};
        cmsb      = as[SLICE-1] ^ bs[SLICE-1] ^ sum[SLICE-1];
        slice_ovf = cmsb ^ sum[SLICE];
        case (op_q)
            OP_AND:  rs = as & bs;
            OP_OR:   rs = as | bs;
            default: rs = sum[SLICE-1:0];
        endcase
        legal   = (ulaOp == OP_AND) || (ulaOp == OP_OR) || (ulaOp == OP_ADD) ||
                  (ulaOp == OP_SUB) || (ulaOp == OP_SLT);
        last    = (cnt_q == CW'(N - 1));
        slt_bit = acc_q[WIDTH-1] ^ sovf_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sovf_d  = sovf_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = ulaOp;
                    a_d   = a;
                    b_d   = b;
                    cnt_d = '0;
                    acc_d = '0;
                    // Carry register starts at the effective carry-in: c_In for ADD, 1 for a+~b+1.
                    carry_d = (ulaOp == OP_ADD) ? c_In :
                              ((ulaOp == OP_SUB) || (ulaOp == OP_SLT));
                    if (legal) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        y_d     = '0;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = sum[SLICE];
                acc_d   = (acc_q >> SLICE) | (WIDTH'(rs) << (WIDTH - SLICE));
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sovf_d = slice_ovf;
                    if (op_q == OP_SLT) begin
                        state_d = FIX;
                    end else begin
                        state_d = DONE;
                        y_d     = acc_d;
                        cout_d  = arith & sum[SLICE];
                        ovf_d   = arith & slice_ovf;
                        zero_d  = (acc_d == '0);
                        err_d   = 1'b0;
                    end
                end
            end
            FIX: begin
                state_d = DONE;
                y_d     = {{(WIDTH-1){1'b0}}, slt_bit};
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                zero_d  = ~slt_bit;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sovf_q  <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sovf_q  <= sovf_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign Y     = y_q;
    assign c_Out = cout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ula_serial.sv
// Directed bench for ula_serial: one WIDTH=8/SLICE=1 and one WIDTH=8/SLICE=4 instance.
module tb_ula_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [2:0] ulaOp = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       c_In = 1'b0;

    logic       busy1, done1, cout1, ovf1, zero1, err1;
    logic [7:0] y1;
    logic       busy4, done4, cout4, ovf4, zero4, err4;
    logic [7:0] y4;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    ula_serial #(.WIDTH(8), .SLICE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start1), .ulaOp(ulaOp), .a(a), .b(b), .c_In(c_In),
        .busy(busy1), .done(done1), .Y(y1), .c_Out(cout1), .ovf(ovf1), .zero(zero1), .err(err1)
    );

    ula_serial #(.WIDTH(8), .SLICE(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start4), .ulaOp(ulaOp), .a(a), .b(b), .c_In(c_In),
        .busy(busy4), .done(done4), .Y(y4), .c_Out(cout4), .ovf(ovf4), .zero(zero4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents an operation across one posedge; returns at the negedge after the start edge.
    task automatic issue(input int sel, input logic [2:0] op, input logic [7:0] aa,
                         input logic [7:0] bb, input logic ci);
        @(negedge clk);
        ulaOp = op; a = aa; b = bb; c_In = ci;
        if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        a = 8'hxx; b = 8'hxx; ulaOp = 3'bxxx; c_In = 1'bx;
    endtask

    // Counts posedges after the start edge until done is seen (bounded).
    task automatic wait_done(input int sel, output int edges);
        edges = 0;
        while (((sel == 4) ? done4 : done1) !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        // Reset held while clocking
        repeat (3) @(negedge clk);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_outs", {y1, cout1, ovf1, zero1, err1}, 12'h000);
        rst = 1'b1;

        issue(1, 3'b010, 8'h03, 8'h04, 1'b0);
        wait_done(1, n);
        chk("add_lat", n, 8);
        chk("add_y", y1, 8'h07);
        chk("add_zero", zero1, 1'b0);

        issue(1, 3'b010, 8'h7F, 8'h01, 1'b1);
        wait_done(1, n);
        chk("ovf_lat", n, 8);
        chk("ovf_flags", {y1, cout1, ovf1, zero1, err1}, {8'h81, 4'b0100});
        @(negedge clk);
        chk("ovf_pulse", done1, 1'b0);
        chk("ovf_idle", busy1, 1'b0);

        issue(1, 3'b110, 8'h05, 8'h05, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_y", y1, 8'h81);
        wait_done(1, n);
        chk("sub_flags", {y1, cout1, ovf1, zero1, err1}, {8'h00, 4'b1010});

        issue(1, 3'b111, 8'h80, 8'h01, 1'b0);
        wait_done(1, n);
        chk("slt_lat", n, 9);
        chk("slt1", {y1, cout1, ovf1, zero1, err1}, {8'h01, 4'b0000});

        issue(1, 3'b111, 8'h01, 8'h80, 1'b0);
        wait_done(1, n);
        chk("slt0", {y1, zero1}, {8'h00, 1'b1});

        issue(1, 3'b000, 8'hCC, 8'hAA, 1'b1);
        wait_done(1, n);
        chk("and", {y1, cout1, ovf1, zero1, err1}, {8'h88, 4'b0000});

        // Start during busy must be ignored
        issue(1, 3'b010, 8'h01, 8'h01, 1'b0);
        @(negedge clk);
        ulaOp = 3'b001; a = 8'hF0; b = 8'h0F; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done1 === 1'b1) n++;
        end
        chk("busy_pulses", n, 1);
        chk("busy_y", y1, 8'h02);
        chk("busy_idle", busy1, 1'b0);

        issue(1, 3'b100, 8'h12, 8'h34, 1'b0);
        wait_done(1, n);
        chk("ill_lat", n, 0);
        chk("ill_flags", {y1, cout1, ovf1, zero1, err1}, {8'h00, 4'b0011});

        issue(4, 3'b010, 8'hFF, 8'h01, 1'b0);
        wait_done(4, n);
        chk("s4_lat", n, 2);
        chk("s4_flags", {y4, cout4, ovf4, zero4, err4}, {8'h00, 4'b1010});

        // Reset one edge into a repeat aborts with no done
        issue(4, 3'b010, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy4, 1'b0);
        chk("abort_outs", {done4, y4, cout4, ovf4, zero4, err4}, 13'h0000);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (done4 === 1'b1) n++;
        end
        chk("abort_nodone", n, 0);
        rst = 1'b1;

        issue(4, 3'b001, 8'hF0, 8'h0F, 1'b0);
        wait_done(4, n);
        chk("s4_or", {n[7:0], y4, zero4}, {8'd2, 8'hFF, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
